conway_sequencer: RTL and testbench

Generation controller for the Game of Life cell array. It drives the shared load and enable lines of all conway cells: it loads the initial pattern, then advances generations in single-step or free-run mode at a programmable rate. It monitors the board vector to count generations and detect stable or extinct boards, optionally halting on them. It sits between the top-level user controls and the cell grid.

---
 rtl/conway_sequencer.sv | 168 ++++++++++++++++
 tb/tb_conway_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conway_sequencer
//  Description : Generation controller for the Game of Life cell array. Loads
//                the initial pattern, then single-steps or free-runs the grid
//                at a programmable rate, tracking stable/extinct boards.
//  Revision    : 1.0  initial release
// ============================================================================
module conway_sequencer #(
    parameter int N        = 64,
    parameter int PERIOD_W = 24,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic                run,
    input  logic                step_req,
    input  logic                halt_on_stable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [GEN_W-1:0]    max_gens,
    input  logic [N-1:0]        board_state,
    output logic                board_rst,
    output logic                board_ena,
    output logic [GEN_W-1:0]    gen_count,
    output logic                running,
    output logic                stable,
    output logic                extinct,
    output logic                done
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_STEP  = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_WAIT  = 3'd4;

    localparam logic [GEN_W-1:0] c_GEN_MAX = {GEN_W{1'b1}};

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [N-1:0]        r_snapshot;
    logic [PERIOD_W-1:0] r_wait;
    logic [GEN_W-1:0]    r_gen;
    logic                r_running;
    logic                r_stable;
    logic                r_extinct;
    logic                r_done;

    logic w_same;
    logic w_zero;
    logic w_halt;

    // In CHECK the board already holds the new generation; the snapshot holds the old one.
    assign w_same = (board_state == r_snapshot);
    assign w_zero = (board_state == '0);
    assign w_halt = (halt_on_stable && (w_same || w_zero)) ||
                    ((max_gens != '0) && (r_gen == max_gens));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (load_req) begin
            w_next = c_ST_LOAD;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run || step_req) begin
                        w_next = c_ST_STEP;
                    end
                end
                c_ST_LOAD:  w_next = c_ST_IDLE;
                c_ST_STEP:  w_next = c_ST_CHECK;
                c_ST_CHECK: begin
                    if (!r_running || w_halt || !run) begin
                        w_next = c_ST_IDLE;
                    end else begin
                        w_next = c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (!run) begin
                        w_next = c_ST_IDLE;
                    end else if (r_wait == '0) begin
                        w_next = c_ST_STEP;
                    end
                end
                default:    w_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        board_rst = (r_state == c_ST_LOAD);
        board_ena = (r_state == c_ST_STEP);
        gen_count = r_gen;
        running   = r_running;
        stable    = r_stable;
        extinct   = r_extinct;
        done      = r_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapshot <= '0;
            r_wait     <= '0;
            r_gen      <= '0;
            r_running  <= 1'b0;
            r_stable   <= 1'b0;
            r_extinct  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A load request pre-empts any step bookkeeping in the current state.
            if (load_req || (r_state == c_ST_LOAD)) begin
                r_gen     <= '0;
                r_running <= 1'b0;
                r_stable  <= 1'b0;
                r_extinct <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (run) begin
                            r_running <= 1'b1;
                        end
                    end
                    c_ST_STEP: begin
                        r_snapshot <= board_state;
                        if (r_gen != c_GEN_MAX) begin
                            r_gen <= r_gen + 1'b1;
                        end
                    end
                    c_ST_CHECK: begin
                        r_stable  <= w_same;
                        r_extinct <= w_zero;
                        if (r_running) begin
                            if (w_halt) begin
                                r_done    <= 1'b1;
                                r_running <= 1'b0;
                            end else if (!run) begin
                                r_running <= 1'b0;
                            end else begin
                                r_wait <= period;
                            end
                        end
                    end
                    c_ST_WAIT: begin
                        if (!run) begin
                            r_running <= 1'b0;
                        end else if (r_wait != '0) begin
                            r_wait <= r_wait - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conway_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conway_sequencer
//  Description : Scoreboard bench for conway_sequencer driving an 8x8 Life
//                board model; directed scenarios plus randomized runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conway_sequencer;

    localparam int N  = 64;
    localparam int PW = 24;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic          run = 1'b0;
    logic          step_req = 1'b0;
    logic          halt_on_stable = 1'b0;
    logic [PW-1:0] period = '0;
    logic [GW-1:0] max_gens = '0;
    logic [N-1:0]  board_state = '0;
    logic          board_rst;
    logic          board_ena;
    logic [GW-1:0] gen_count;
    logic          running;
    logic          stable;
    logic          extinct;
    logic          done;

    conway_sequencer #(.N(N), .PERIOD_W(PW), .GEN_W(GW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .run(run), .step_req(step_req),
        .halt_on_stable(halt_on_stable), .period(period), .max_gens(max_gens),
        .board_state(board_state), .board_rst(board_rst), .board_ena(board_ena),
        .gen_count(gen_count), .running(running), .stable(stable),
        .extinct(extinct), .done(done)
    );

    always #5 clk = ~clk;

    // 8x8 Life rule with dead cells beyond the edge
    function automatic logic [63:0] life(input logic [63:0] b);
        logic [63:0] nb;
        int n;
        nb = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8) begin
                            n += int'(b[(r + dr) * 8 + c + dc]);
                        end
                    end
                end
                nb[r * 8 + c] = (n == 3) || (n == 2 && b[r * 8 + c]);
            end
        end
        return nb;
    endfunction

    logic [63:0] pat = '0;
    always @(posedge clk) begin
        if (board_rst)      board_state <= pat;
        else if (board_ena) board_state <= life(board_state);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit is_done;
        int gen;
        int off;
        bit run_m;
        bit stab;
        bit ext;
    } ev_t;

    ev_t q[$];

    function automatic ev_t mk(bit d, int g, int o, bit r, bit s, bit x);
        ev_t e;
        e.is_done = d; e.gen = g; e.off = o; e.run_m = r; e.stab = s; e.ext = x;
        return e;
    endfunction

    // Monitor: pops an expected event whenever the DUT strobes board_ena or done.
    ev_t e;
    int base = 0;
    always @(negedge clk) begin
        if (board_ena) begin
            if (q.size() == 0) begin
                chk("unexpected_ena", 1, 0);
            end else begin
                e = q.pop_front();
                chk("ena_kind", e.is_done, 0);
                chk("ena_gen_count", gen_count, e.gen - 1);
                chk("ena_running", running, e.run_m);
                if (e.off == 0)     base = cyc;
                else if (e.off > 0) chk("ena_spacing", cyc - base, e.off);
            end
        end
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_kind", e.is_done, 1);
                chk("done_gen_count", gen_count, e.gen);
                chk("done_stable", stable, e.stab);
                chk("done_extinct", extinct, e.ext);
                chk("done_running", running, 0);
                chk("done_timing", cyc - base, e.off);
            end
        end
    end

    logic [63:0] mb;
    int mgen;

    task automatic do_load(input logic [63:0] p);
        pat = p;
        load_req = 1'b1; run = 1'b0; step_req = 1'b0;
        @(posedge clk); #1;
        load_req = 1'b0;
        @(negedge clk);
        chk("load_board_rst_high", board_rst, 1);
        chk("load_no_ena", board_ena, 0);
        @(negedge clk);
        chk("load_board_rst_one_cycle", board_rst, 0);
        chk("load_gen_count", gen_count, 0);
        chk("load_stable", stable, 0);
        chk("load_extinct", extinct, 0);
        chk("load_running", running, 0);
        chk("load_board_model", board_state == p, 1);
        mb = p; mgen = 0;
    endtask

    task automatic do_step();
        logic [63:0] nb;
        nb = life(mb);
        q.push_back(mk(0, mgen + 1, -1, 0, 0, 0));
        @(posedge clk); #1;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        mgen++;
        chk("step_gen_count", gen_count, mgen);
        chk("step_stable", stable, nb == mb);
        chk("step_extinct", extinct, nb == '0);
        chk("step_running", running, 0);
        chk("step_queue_empty", q.size(), 0);
        mb = nb;
    endtask

    task automatic do_run(input int p, input bit h, input int m);
        logic [63:0] b, nb;
        int k, fin;
        bit s, x, found;
        b = mb; fin = mgen;
        for (k = 1; k <= 64; k++) begin
            nb = life(b);
            s = (nb == b); x = (nb == '0);
            q.push_back(mk(0, mgen + k, (k - 1) * (p + 3), 1, 0, 0));
            b = nb; fin = mgen + k;
            if ((h && (s || x)) || (m != 0 && mgen + k == m)) begin
                q.push_back(mk(1, mgen + k, (k - 1) * (p + 3) + 2, 0, s, x));
                break;
            end
        end
        period = PW'(p); halt_on_stable = h; max_gens = GW'(m);
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (done) begin
                run = 1'b0;
                found = 1;
                break;
            end
        end
        run = 1'b0;
        chk("run_done_seen", found, 1);
        repeat (4) @(negedge clk);
        mgen = fin; mb = b;
        chk("run_queue_empty", q.size(), 0);
        chk("run_final_gen_count", gen_count, mgen);
        chk("run_final_running", running, 0);
        q.delete();
    endtask

    localparam logic [63:0] c_BLINKER = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    localparam logic [63:0] c_BLOCK   = (64'd1 << 27) | (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 36);
    localparam logic [63:0] c_GLIDER  = (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 25) |
                                        (64'd1 << 26) | (64'd1 << 27);
    localparam logic [63:0] c_SINGLE  = (64'd1 << 36);

    initial begin
        bit seen;
        logic [63:0] rp;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_board_rst", board_rst, 0);
        chk("reset_board_ena", board_ena, 0);
        chk("reset_gen_count", gen_count, 0);
        chk("reset_running", running, 0);
        chk("reset_stable", stable, 0);
        chk("reset_extinct", extinct, 0);
        chk("reset_done", done, 0);

        do_load(c_BLINKER);
        do_step();
        do_step();

        do_load(c_BLOCK);
        do_run(5, 1'b1, 0);

        do_load(c_GLIDER);
        do_run(0, 1'b0, 4);

        do_load(c_SINGLE);
        do_run(3, 1'b1, 0);

        // Load while waiting between generations aborts the run
        do_load(c_GLIDER);
        q.push_back(mk(0, 1, 0, 1, 0, 0));
        period = PW'(100); halt_on_stable = 1'b0; max_gens = '0;
        run = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (board_ena) begin
                seen = 1;
                break;
            end
        end
        chk("midwait_first_ena", seen, 1);
        repeat (10) @(negedge clk);
        chk("midwait_running_before_load", running, 1);
        do_load(c_GLIDER);
        repeat (20) @(negedge clk);
        chk("midwait_no_further_ena", q.size(), 0);
        chk("midwait_gen_count", gen_count, 0);
        q.delete();

        for (int t = 0; t < 8; t++) begin
            rp = {$urandom, $urandom} & {$urandom, $urandom};
            do_load(rp);
            if ($urandom_range(0, 2) == 0) begin
                do_step();
                do_step();
            end else begin
                do_run(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)),
                       int'($urandom_range(1, 6)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
